// File: rtl/sensor_emu_pkg.sv
// Shared encodings, beat-layout constants and the word-replication compare for the LVDS frame checker.
// Pure declarations: no latency, no backpressure.
package sensor_emu_pkg;

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_IDLE = 2'd1,
    S_BODY = 2'd2
  } state_e;

  typedef enum logic {
    IDLE0 = 1'b0,
    IDLE1 = 1'b1
  } idle_ph_e;

  localparam int LVDS_W      = 512;
  localparam int PAT_W       = 32;
  localparam int NWORDS      = LVDS_W / PAT_W;
  localparam int HDR_LSB     = 480;
  localparam int PAD_LSB     = 384;
  localparam int LC_PAD_BITS = 32;
  localparam int IDLE_REP    = LVDS_W / 8;

  // Which 32-bit words of a beat carry cell data for each layout.
  localparam logic [NWORDS-1:0] FC_MASK = 16'h0FFF;
  localparam logic [NWORDS-1:0] DC_MASK = 16'hFFFF;
  localparam logic [NWORDS-1:0] LC_MASK = 16'hFFFE;

  function automatic logic words_match(input logic [LVDS_W-1:0] beat,
                                       input logic [PAT_W-1:0]  pat,
                                       input logic [NWORDS-1:0] mask);
    logic ok;
    ok = 1'b1;
    for (int w = 0; w < NWORDS; w++) begin
      if (mask[w] && (beat[w*PAT_W +: PAT_W] != pat)) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones; synchronous clear beats a same-cycle increment.
// Latency 1 clk from inc to count; never stalls.
module sat_counter32 (
  input  logic        clk,
  input  logic        resetn,
  input  logic        clear,
  input  logic        inc,
  output logic [31:0] count
);

  logic [31:0] count_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sensor_frame_checker.sv
// Frames the raw LVDS beat stream from data alone, checks idle/header/length/data, reports one pattern per frame.
// Latency 2 clk lvds->counters/stream; a result closing while the held one is unaccepted is dropped and counted.
module sensor_frame_checker
  import sensor_emu_pkg::*;
#(
  parameter int PATTERN_WIDTH = 32,
  parameter int LVDS_WIDTH    = 512
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [LVDS_WIDTH-1:0]    lvds,
  input  logic [31:0]              cycles_per_frame,
  input  logic [7:0]               idle_0,
  input  logic [7:0]               idle_1,
  input  logic [31:0]              frame_header,
  input  logic                     clear,
  output logic [31:0]              frame_count,
  output logic [31:0]              err_idle,
  output logic [31:0]              err_header,
  output logic [31:0]              err_length,
  output logic [31:0]              err_data,
  output logic [31:0]              drop_count,
  output logic [PATTERN_WIDTH-1:0] M_AXIS_TDATA,
  output logic                     M_AXIS_TUSER,
  output logic                     M_AXIS_TVALID,
  input  logic                     M_AXIS_TREADY
);

  logic [LVDS_WIDTH-1:0]    lvds_q;
  state_e                   state_q, state_d;
  idle_ph_e                 last_idle_q, last_idle_d;
  logic [31:0]              cyc_q, cyc_d, beat_no;
  logic [PATTERN_WIDTH-1:0] pat_q, pat_d;
  logic                     ferr_q, ferr_d;
  logic                     tvalid_q, tvalid_d;
  logic                     tuser_q, tuser_d;
  logic [PATTERN_WIDTH-1:0] tdata_q, tdata_d;

  logic is_idle0, is_idle1, hdr_match, pad_zero, is_hdr, is_bad_hdr;
  logic fc_ok, dc_ok, lc_ok, lc_pad_ok, is_last;
  logic start, close, close_err;
  logic inc_idle, inc_hdr, inc_len, inc_data, inc_drop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lvds_q <= '0;
    else         lvds_q <= lvds;
  end

  assign is_idle0   = (lvds_q == {IDLE_REP{idle_0}});
  assign is_idle1   = (lvds_q == {IDLE_REP{idle_1}});
  assign hdr_match  = (lvds_q[LVDS_WIDTH-1:HDR_LSB] == frame_header);
  assign pad_zero   = (lvds_q[HDR_LSB-1:PAD_LSB] == '0);
  assign is_hdr     = hdr_match && pad_zero;
  assign is_bad_hdr = hdr_match && !pad_zero;
  assign fc_ok      = words_match(lvds_q, lvds_q[PATTERN_WIDTH-1:0], FC_MASK);
  assign dc_ok      = words_match(lvds_q, pat_q, DC_MASK);
  assign lc_ok      = words_match(lvds_q, pat_q, LC_MASK);
  assign lc_pad_ok  = (lvds_q[LC_PAD_BITS-1:0] == '0);
  assign beat_no    = cyc_q + 32'd1;
  assign is_last    = (beat_no == cycles_per_frame);

  always_comb begin
    state_d     = state_q;
    last_idle_d = last_idle_q;
    cyc_d       = cyc_q;
    pat_d       = pat_q;
    ferr_d      = ferr_q;
    start       = 1'b0;
    close       = 1'b0;
    close_err   = 1'b0;
    inc_idle    = 1'b0;
    inc_hdr     = 1'b0;
    inc_len     = 1'b0;
    inc_data    = 1'b0;

    case (state_q)
      S_HUNT: begin
        if (is_idle1) begin
          state_d     = S_IDLE;
          last_idle_d = IDLE1;
        end
      end
      S_IDLE: begin
        if (is_idle0) begin
          inc_idle    = (last_idle_q == IDLE0);
          last_idle_d = IDLE0;
        end else if (is_idle1) begin
          inc_idle    = (last_idle_q == IDLE1);
          last_idle_d = IDLE1;
        end else if (is_hdr) begin
          start    = 1'b1;
          inc_idle = (last_idle_q == IDLE0);
        end else if (is_bad_hdr) begin
          inc_hdr = 1'b1;
        end else begin
          inc_idle = 1'b1;
        end
      end
      S_BODY: begin
        if (is_last) begin
          close       = 1'b1;
          inc_len     = !lc_pad_ok;
          inc_data    = !lc_ok;
          close_err   = ferr_q | inc_len | inc_data;
          state_d     = S_IDLE;
          last_idle_d = IDLE1;
        end else if (is_hdr) begin
          // Early header: short frame is closed and the new one starts on this beat.
          close     = 1'b1;
          inc_len   = 1'b1;
          close_err = 1'b1;
          start     = 1'b1;
        end else begin
          inc_data = !dc_ok;
          ferr_d   = ferr_q | inc_data;
          cyc_d    = beat_no;
        end
      end
      default: state_d = S_HUNT;
    endcase

    if (start) begin
      state_d  = S_BODY;
      cyc_d    = 32'd1;
      pat_d    = lvds_q[PATTERN_WIDTH-1:0];
      inc_data = !fc_ok;
      ferr_d   = inc_data | inc_idle;
    end
  end

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    inc_drop = 1'b0;
    if (tvalid_q && M_AXIS_TREADY) tvalid_d = 1'b0;
    if (close) begin
      if (tvalid_q && !M_AXIS_TREADY) begin
        inc_drop = 1'b1;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = pat_q;
        tuser_d  = close_err;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_HUNT;
      last_idle_q <= IDLE1;
      cyc_q       <= '0;
      pat_q       <= '0;
      ferr_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_idle_q <= last_idle_d;
      cyc_q       <= cyc_d;
      pat_q       <= pat_d;
      ferr_q      <= ferr_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
    end
  end

  assign M_AXIS_TVALID = tvalid_q;
  assign M_AXIS_TDATA  = tdata_q;
  assign M_AXIS_TUSER  = tuser_q;

  sat_counter32 u_cnt_frame  (.clk(clk), .resetn(resetn), .clear(clear), .inc(close),    .count(frame_count));
  sat_counter32 u_cnt_idle   (.clk(clk), .resetn(resetn), .clear(clear), .inc(inc_idle), .count(err_idle));
  sat_counter32 u_cnt_header (.clk(clk), .resetn(resetn), .clear(clear), .inc(inc_hdr),  .count(err_header));
  sat_counter32 u_cnt_length (.clk(clk), .resetn(resetn), .clear(clear), .inc(inc_len),  .count(err_length));
  sat_counter32 u_cnt_data   (.clk(clk), .resetn(resetn), .clear(clear), .inc(inc_data), .count(err_data));
  sat_counter32 u_cnt_drop   (.clk(clk), .resetn(resetn), .clear(clear), .inc(inc_drop), .count(drop_count));

endmodule

// File: tb/tb_sensor_frame_checker.sv
// Directed bench for sensor_frame_checker: idle/header classification table plus frame-level sequences.
// Beats are driven on the falling edge; one beat per clock, outputs read on the falling edge.
module tb_sensor_frame_checker;

  localparam logic [7:0]  I0  = 8'hA5;
  localparam logic [7:0]  I1  = 8'h5A;
  localparam logic [31:0] HDR = 32'hDEADBEEF;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic [511:0] lvds = '0;
  logic [31:0]  cycles_per_frame = 32'd8;
  logic [7:0]   idle_0 = I0;
  logic [7:0]   idle_1 = I1;
  logic [31:0]  frame_header = HDR;
  logic         clear = 1'b0;
  logic [31:0]  frame_count, err_idle, err_header, err_length, err_data, drop_count;
  logic [31:0]  M_AXIS_TDATA;
  logic         M_AXIS_TUSER, M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b1;

  always #5 clk = ~clk;

  sensor_frame_checker dut (
    .clk(clk), .resetn(resetn), .lvds(lvds), .cycles_per_frame(cycles_per_frame),
    .idle_0(idle_0), .idle_1(idle_1), .frame_header(frame_header), .clear(clear),
    .frame_count(frame_count), .err_idle(err_idle), .err_header(err_header),
    .err_length(err_length), .err_data(err_data), .drop_count(drop_count),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  bit          tb_last = 1'b1;
  logic [32:0] sq[$];

  // Accepted stream beats, as {TUSER, TDATA}; handshake completes on the next rising edge.
  always begin
    @(negedge clk);
    #2;
    if (M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) sq.push_back({M_AXIS_TUSER, M_AXIS_TDATA});
  end

  function automatic logic [511:0] idle_b(input logic [7:0] b); return {64{b}}; endfunction
  function automatic logic [511:0] fc_b(input logic [31:0] p); return {HDR, 96'h0, {12{p}}}; endfunction
  function automatic logic [511:0] dc_b(input logic [31:0] p); return {16{p}}; endfunction
  function automatic logic [511:0] lc_b(input logic [31:0] p); return {{15{p}}, 32'h0}; endfunction

  function automatic logic [63:0] qget(input int i);
    if (i < sq.size()) return 64'(sq[i]);
    return 64'hDEAD_0000_DEAD_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [511:0] v);
    lvds = v;
    @(negedge clk);
  endtask

  task automatic send_idle(input int n);
    for (int i = 0; i < n; i++) begin
      tb_last = ~tb_last;
      beat(idle_b(tb_last ? I1 : I0));
    end
  endtask

  // bad_beats bit c corrupts middle beat c (2..7) in the words selected by bad_words.
  task automatic send_frame(input logic [31:0] p, input logic [7:0] bad_beats = '0,
                            input logic [15:0] bad_words = '0, input logic [31:0] lc_pad = '0);
    logic [511:0] d;
    if (!tb_last) send_idle(1);
    beat(fc_b(p));
    for (int c = 2; c <= 7; c++) begin
      d = dc_b(p);
      if (bad_beats[c])
        for (int w = 0; w < 16; w++) if (bad_words[w]) d[w*32 +: 32] = 32'h12345678;
      beat(d);
    end
    d = lc_b(p);
    d[31:0] = lc_pad;
    beat(d);
    tb_last = 1'b1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    send_idle(1);
    clear = 1'b0;
    send_idle(2);
    sq.delete();
  endtask

  typedef struct {
    logic [511:0] beat;
    logic [31:0]  exp_idle;
    logic [31:0]  exp_hdr;
  } vec_t;

  vec_t tab [15];

  initial begin
    logic [511:0] garb, badh;
    garb = {16{32'h1234_5678}};
    badh = {HDR, 96'h1, 384'h0};
    // Expected counts reflect the rows before each row (2-clock decision latency).
    tab[0]  = '{garb,       32'd0, 32'd0};
    tab[1]  = '{idle_b(I0), 32'd0, 32'd0};
    tab[2]  = '{badh,       32'd0, 32'd0};
    tab[3]  = '{idle_b(I1), 32'd0, 32'd0};
    tab[4]  = '{idle_b(I0), 32'd0, 32'd0};
    tab[5]  = '{idle_b(I1), 32'd0, 32'd0};
    tab[6]  = '{idle_b(I0), 32'd0, 32'd0};
    tab[7]  = '{idle_b(I0), 32'd0, 32'd0};
    tab[8]  = '{idle_b(I1), 32'd1, 32'd0};
    tab[9]  = '{badh,       32'd1, 32'd0};
    tab[10] = '{idle_b(I0), 32'd1, 32'd1};
    tab[11] = '{garb,       32'd1, 32'd1};
    tab[12] = '{idle_b(I1), 32'd2, 32'd1};
    tab[13] = '{idle_b(I1), 32'd2, 32'd1};
    tab[14] = '{idle_b(I0), 32'd3, 32'd1};

    repeat (2) @(negedge clk);
    check("rst frame_count", frame_count, 0);
    check("rst err_idle", err_idle, 0);
    check("rst err_header", err_header, 0);
    check("rst err_length", err_length, 0);
    check("rst err_data", err_data, 0);
    check("rst drop_count", drop_count, 0);
    check("rst tvalid", M_AXIS_TVALID, 0);
    check("rst tdata", M_AXIS_TDATA, 0);
    check("rst tuser", M_AXIS_TUSER, 0);
    resetn = 1'b1;

    for (int i = 0; i < 15; i++) begin
      beat(tab[i].beat);
      check($sformatf("tab%0d err_idle", i), err_idle, tab[i].exp_idle);
      check($sformatf("tab%0d err_header", i), err_header, tab[i].exp_hdr);
      check($sformatf("tab%0d frame_count", i), frame_count, 0);
    end
    tb_last = 1'b0;

    // Clean back-to-back traffic
    do_clear();
    check("clear err_idle", err_idle, 0);
    send_idle(20);
    send_frame(32'h1);
    send_frame(32'h2);
    send_frame(32'h3);
    send_idle(1);
    check("clean tvalid rise", M_AXIS_TVALID, 1);
    check("clean tdata", M_AXIS_TDATA, 32'h3);
    send_idle(1);
    check("clean tvalid fall", M_AXIS_TVALID, 0);
    send_idle(1);
    check("clean frame_count", frame_count, 3);
    check("clean err_idle", err_idle, 0);
    check("clean err_length", err_length, 0);
    check("clean err_data", err_data, 0);
    check("clean q size", sq.size(), 3);
    for (int i = 0; i < 3; i++) check($sformatf("clean q%0d", i), qget(i), {1'b0, 32'(i + 1)});

    // Early header at beat 5
    do_clear();
    if (!tb_last) send_idle(1);
    beat(fc_b(32'h10));
    repeat (3) beat(dc_b(32'h10));
    send_frame(32'h20);
    send_idle(3);
    check("early err_length", err_length, 1);
    check("early frame_count", frame_count, 2);
    check("early err_data", err_data, 0);
    check("early q0", qget(0), {1'b1, 32'h10});
    check("early q1", qget(1), {1'b0, 32'h20});

    // Data errors: one bad word, two bad words in one beat, then a nonzero LC pad
    do_clear();
    send_frame(32'h30, 8'b0000_1000, 16'h0020);
    send_idle(2);
    check("data one err_data", err_data, 1);
    send_frame(32'h31, 8'b0001_0000, 16'h8001);
    send_frame(32'h32, 8'h00, 16'h0000, 32'h1);
    send_idle(3);
    check("data two err_data", err_data, 2);
    check("lcpad err_length", err_length, 1);
    check("data q0", qget(0), {1'b1, 32'h30});
    check("data q1", qget(1), {1'b1, 32'h31});
    check("data q2", qget(2), {1'b1, 32'h32});

    // Back-pressure across two closes
    do_clear();
    M_AXIS_TREADY = 1'b0;
    send_frame(32'h40);
    send_frame(32'h41);
    send_idle(3);
    check("bp tvalid held", M_AXIS_TVALID, 1);
    check("bp tdata held", M_AXIS_TDATA, 32'h40);
    check("bp drop_count", drop_count, 1);
    check("bp frame_count", frame_count, 2);
    M_AXIS_TREADY = 1'b1;
    send_idle(2);
    check("bp tvalid after", M_AXIS_TVALID, 0);
    check("bp q size", sq.size(), 1);
    check("bp q0", qget(0), {1'b0, 32'h40});

    // Idle phase errors
    do_clear();
    if (!tb_last) send_idle(1);
    beat(idle_b(I0));
    beat(idle_b(I0));
    beat(idle_b(I1));
    tb_last = 1'b1;
    send_frame(32'h50);
    beat(idle_b(I0));
    tb_last = 1'b1;  // header straight after IDLE0 on purpose
    send_frame(32'h51);
    send_idle(3);
    check("phase err_idle", err_idle, 2);
    check("phase frame_count", frame_count, 2);
    check("phase err_data", err_data, 0);
    check("phase q0", qget(0), {1'b0, 32'h50});

    // Reset mid-frame, then HUNT must ignore garbage until IDLE1
    sq.delete();
    if (!tb_last) send_idle(1);
    beat(fc_b(32'h60));
    beat(dc_b(32'h60));
    beat(dc_b(32'h60));
    lvds = dc_b(32'h60);
    resetn = 1'b0;
    @(negedge clk);
    check("mrst frame_count", frame_count, 0);
    check("mrst err_idle", err_idle, 0);
    check("mrst tvalid", M_AXIS_TVALID, 0);
    check("mrst tdata", M_AXIS_TDATA, 0);
    resetn = 1'b1;
    repeat (3) beat(dc_b(32'h60));
    beat(fc_b(32'h61));
    beat(idle_b(I0));
    beat(lc_b(32'h60));
    beat(idle_b(I1));
    tb_last = 1'b1;
    send_idle(2);
    check("hunt err_idle", err_idle, 0);
    check("hunt err_header", err_header, 0);
    check("hunt err_data", err_data, 0);
    check("hunt frame_count", frame_count, 0);
    send_frame(32'h62);
    send_idle(3);
    check("hunt frame_count after", frame_count, 1);
    check("hunt q size", sq.size(), 1);
    check("hunt q0", qget(0), {1'b0, 32'h62});

    // Saturation
    force dut.u_cnt_data.count_q = 32'hFFFF_FFFE;
    send_idle(1);
    release dut.u_cnt_data.count_q;
    send_idle(1);
    check("sat preload", err_data, 32'hFFFF_FFFE);
    send_frame(32'h70, 8'b0001_1100, 16'h0001);
    send_idle(2);
    check("sat err_data", err_data, 32'hFFFF_FFFF);

    // Clear on the same cycle as an idle error
    beat(idle_b(tb_last ? I1 : I0));
    clear = 1'b1;
    send_idle(1);
    clear = 1'b0;
    send_idle(2);
    check("clrwin err_idle", err_idle, 0);
    check("clrwin err_data", err_data, 0);
    check("clrwin frame_count", frame_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
